// File: rtl/router_port_arbiter.sv
// Round-robin arbiter sharing one router output link between N_REQ requesters.
// The winning packet is held in an output register until the downstream hop acks it or it times out.
module router_port_arbiter #(
  parameter int N_REQ       = 5,
  parameter int PKT_W       = 34,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           in_req,
  input  logic [N_REQ*PKT_W-1:0]     in_packet,
  output logic [N_REQ-1:0]           in_ack,
  output logic                       out_req,
  output logic [PKT_W-1:0]           out_packet,
  input  logic                       out_ack,
  output logic [$clog2(N_REQ)-1:0]   grant_idx,
  output logic                       busy,
  input  logic                       err_clr,
  output logic                       timeout_err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [N_REQ-1:0]   win_onehot;
  logic [IDX_W-1:0]   next_ptr;
  logic               timeout_hit;

  // Scan requesters starting at ptr and wrapping; first asserted request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      int unsigned idx;
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && in_req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx[IDX_W-1:0];
      end
    end
  end

  assign win_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
  assign next_ptr    = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign busy        = (state == SEND);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      in_ack      <= '0;
      out_req     <= 1'b0;
      out_packet  <= '0;
      grant_idx   <= '0;
      timeout_err <= 1'b0;
    end else begin
      in_ack <= '0;
      // A timeout below overrides this clear on the same edge.
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            out_packet <= in_packet[win_idx*PKT_W +: PKT_W];
            in_ack     <= win_onehot;
            out_req    <= 1'b1;
            grant_idx  <= win_idx;
            cnt        <= '0;
            state      <= SEND;
          end
        end
        SEND: begin
          if (out_ack) begin
            out_req <= 1'b0;
            ptr     <= next_ptr;
            state   <= IDLE;
          end else if (timeout_hit) begin
            out_req     <= 1'b0;
            timeout_err <= 1'b1;
            ptr         <= next_ptr;
            state       <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_port_arbiter.sv
// Bench for router_port_arbiter: table-driven round-robin vectors, hand-written corner
// sequences, and randomized traffic compared against a cycle-level reference model.
module tb_router_port_arbiter;

  localparam int N     = 5;
  localparam int PW    = 34;
  localparam int T     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      in_req;
  logic [N*PW-1:0]   in_packet;
  logic [N-1:0]      in_ack;
  logic              out_req;
  logic [PW-1:0]     out_packet;
  logic              out_ack;
  logic [2:0]        grant_idx;
  logic              busy;
  logic              err_clr;
  logic              timeout_err;

  logic [PW-1:0]     pkt_arr [N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    in_packet = '0;
    for (int i = 0; i < N; i++) in_packet[i*PW +: PW] = pkt_arr[i];
  end

  router_port_arbiter #(.N_REQ(N), .PKT_W(PW), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_packet(in_packet), .in_ack(in_ack),
    .out_req(out_req), .out_packet(out_packet), .out_ack(out_ack), .grant_idx(grant_idx),
    .busy(busy), .err_clr(err_clr), .timeout_err(timeout_err)
  );

  // Reference model state: what the link is doing, in plain terms.
  bit          m_sending;
  int          m_ptr;
  int          m_winner;
  int          m_age;
  bit          m_err;
  logic [PW-1:0] m_pkt;
  logic [N-1:0]  m_ack;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sending = 0; m_ptr = 0; m_winner = 0; m_age = 0; m_err = 0; m_pkt = '0; m_ack = '0;
  endtask

  // Advance the model by one rising edge using the inputs currently presented.
  task automatic model_edge();
    bit set_err;
    set_err = 0;
    m_ack = '0;
    if (!m_sending) begin
      for (int j = 0; j < N; j++) begin
        int c;
        c = (m_ptr + j) % N;
        if (in_req[c]) begin
          m_winner  = c;
          m_pkt     = pkt_arr[c];
          m_ack[c]  = 1'b1;
          m_sending = 1;
          m_age     = 0;
          break;
        end
      end
    end else if (out_ack) begin
      m_sending = 0;
      m_ptr     = (m_winner + 1) % N;
    end else if (m_age == T - 1) begin
      m_sending = 0;
      m_ptr     = (m_winner + 1) % N;
      set_err   = 1;
    end else begin
      m_age++;
    end
    if (set_err) m_err = 1;
    else if (err_clr) m_err = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".in_ack"},      64'(in_ack),      64'(m_ack));
    chk({tag, ".out_req"},     64'(out_req),     64'(m_sending));
    chk({tag, ".busy"},        64'(busy),        64'(m_sending));
    chk({tag, ".out_packet"},  64'(out_packet),  64'(m_pkt));
    chk({tag, ".grant_idx"},   64'(grant_idx),   64'(m_winner));
    chk({tag, ".timeout_err"}, 64'(timeout_err), 64'(m_err));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; in_req = '0; out_ack = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ack", 64'(in_ack), 64'(0));
    chk("rst.out_req", 64'(out_req), 64'(0));
    chk("rst.out_packet", 64'(out_packet), 64'(0));
    chk("rst.grant_idx", 64'(grant_idx), 64'(0));
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.timeout_err", 64'(timeout_err), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         ack;
    logic [N-1:0] e_ack;
    logic         e_oreq;
    logic [2:0]   e_g;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // All five requesting, out_ack tied high: one grant every two cycles, 0..4 then 0.
    tbl[0]  = '{5'h1F, 1'b1, 5'h01, 1'b1, 3'd0};
    tbl[1]  = '{5'h1F, 1'b1, 5'h00, 1'b0, 3'd0};
    tbl[2]  = '{5'h1F, 1'b1, 5'h02, 1'b1, 3'd1};
    tbl[3]  = '{5'h1F, 1'b1, 5'h00, 1'b0, 3'd1};
    tbl[4]  = '{5'h1F, 1'b1, 5'h04, 1'b1, 3'd2};
    tbl[5]  = '{5'h1F, 1'b1, 5'h00, 1'b0, 3'd2};
    tbl[6]  = '{5'h1F, 1'b1, 5'h08, 1'b1, 3'd3};
    tbl[7]  = '{5'h1F, 1'b1, 5'h00, 1'b0, 3'd3};
    tbl[8]  = '{5'h1F, 1'b1, 5'h10, 1'b1, 3'd4};
    tbl[9]  = '{5'h1F, 1'b1, 5'h00, 1'b0, 3'd4};
    tbl[10] = '{5'h1F, 1'b1, 5'h01, 1'b1, 3'd0};
    tbl[11] = '{5'h1F, 1'b1, 5'h00, 1'b0, 3'd0};
    // Only 1 and 3 requesting with ptr=1: 1, 3, 1.
    tbl[12] = '{5'h0A, 1'b1, 5'h02, 1'b1, 3'd1};
    tbl[13] = '{5'h0A, 1'b1, 5'h00, 1'b0, 3'd1};
    tbl[14] = '{5'h0A, 1'b1, 5'h08, 1'b1, 3'd3};
    tbl[15] = '{5'h0A, 1'b1, 5'h00, 1'b0, 3'd3};
    tbl[16] = '{5'h0A, 1'b1, 5'h02, 1'b1, 3'd1};
    tbl[17] = '{5'h0A, 1'b1, 5'h00, 1'b0, 3'd1};

    for (int i = 0; i < N; i++) pkt_arr[i] = {2'(i), 32'hC0DE_0000 + 32'(i)};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      in_req  = tbl[i].req;
      out_ack = tbl[i].ack;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.in_ack", i),    64'(in_ack),    64'(tbl[i].e_ack));
      chk($sformatf("tbl%0d.out_req", i),   64'(out_req),   64'(tbl[i].e_oreq));
      chk($sformatf("tbl%0d.grant_idx", i), 64'(grant_idx), 64'(tbl[i].e_g));
      if (tbl[i].e_ack != '0)
        chk($sformatf("tbl%0d.out_packet", i), 64'(out_packet), 64'(pkt_arr[tbl[i].e_g]));
    end

    // Single request on requester 2, acked during cycle 3.
    do_reset();
    pkt_arr[2] = 34'h2_DEADBEEF;
    in_req = 5'b00100;
    step();
    chk("single.in_ack1", 64'(in_ack), 64'(5'b00100));
    chk("single.out_req1", 64'(out_req), 64'(1));
    chk("single.pkt1", 64'(out_packet), 64'(34'h2_DEADBEEF));
    in_req = '0;
    step();
    chk("single.in_ack2", 64'(in_ack), 64'(0));
    chk("single.out_req2", 64'(out_req), 64'(1));
    step();
    chk("single.out_req3", 64'(out_req), 64'(1));
    chk("single.pkt3", 64'(out_packet), 64'(34'h2_DEADBEEF));
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    chk("single.out_req4", 64'(out_req), 64'(0));
    chk("single.busy4", 64'(busy), 64'(0));
    chk("single.err4", 64'(timeout_err), 64'(0));

    // Timeout with err_clr on the dropping edge: set wins, then a later clear.
    do_reset();
    in_req = 5'b00001;
    step();
    in_req = '0;
    for (int c = 2; c <= 4; c++) begin
      step();
      chk($sformatf("tmo.out_req%0d", c), 64'(out_req), 64'(1));
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("tmo.out_req5", 64'(out_req), 64'(0));
    chk("tmo.err5", 64'(timeout_err), 64'(1));
    step(); step();
    chk("tmo.err_sticky", 64'(timeout_err), 64'(1));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("tmo.err_cleared", 64'(timeout_err), 64'(0));
    in_req = 5'h1F;
    step();
    in_req = '0;
    chk("tmo.ptr_adv", 64'(grant_idx), 64'(1));
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;

    // out_ack on the edge where the timeout would fire: normal completion.
    do_reset();
    in_req = 5'b01000;
    step();
    in_req = '0;
    step(); step(); step();
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    chk("ackwin.out_req", 64'(out_req), 64'(0));
    chk("ackwin.err", 64'(timeout_err), 64'(0));

    // Asynchronous reset in the middle of SEND.
    do_reset();
    in_req = 5'b10000;
    step();
    chk("midrst.busy_pre", 64'(busy), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("midrst.out_req", 64'(out_req), 64'(0));
    chk("midrst.busy", 64'(busy), 64'(0));
    chk("midrst.in_ack", 64'(in_ack), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    in_req = 5'h1F;
    step();
    chk("midrst.grant0", 64'(grant_idx), 64'(0));
    chk("midrst.ack0", 64'(in_ack), 64'(5'b00001));

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      in_req  = 5'($urandom);
      out_ack = ($urandom_range(2, 0) == 0);
      err_clr = ($urandom_range(15, 0) == 0);
      for (int i = 0; i < N; i++) pkt_arr[i] = {2'($urandom), 32'($urandom)};
      step();
      check_model($sformatf("rnd%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
